// File: rtl/vit_enc_arb_pkg.sv
// Shared types and helpers for the viterbi encoder arbiter and its round-robin picker.
package vit_enc_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vit_rr_pick.sv
// Combinational round-robin picker: first set request at or above iptr, wrapping modulo pREQ_NUM.
module vit_rr_pick
    import vit_enc_arb_pkg::*;
#(
    parameter int pREQ_NUM = 4,
    parameter int pIDX_W   = idx_w(pREQ_NUM)
) (
    input  logic [pREQ_NUM-1:0] ireq,
    input  logic [pIDX_W-1:0]   iptr,
    output logic                ofound,
    output logic [pIDX_W-1:0]   oidx
);

    // Outer loop walks priority order, inner loop maps it to a constant bit index.
    always_comb begin
        ofound = 1'b0;
        oidx   = '0;
        for (int i = 0; i < pREQ_NUM; i++) begin
            for (int j = 0; j < pREQ_NUM; j++) begin
                if (!ofound && ireq[j] && ((int'(iptr) + i) % pREQ_NUM) == j) begin
                    ofound = 1'b1;
                    oidx   = pIDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/vit_enc_arb.sv
// Frame-level round-robin arbiter sharing one convolutional encoder between bit-serial requesters.
module vit_enc_arb
    import vit_enc_arb_pkg::*;
#(
    parameter int pREQ_NUM = 4,
    parameter int pIDX_W   = idx_w(pREQ_NUM)
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic [pREQ_NUM-1:0] ireq_sop,
    input  logic [pREQ_NUM-1:0] ireq_val,
    input  logic [pREQ_NUM-1:0] ireq_eop,
    input  logic [pREQ_NUM-1:0] ireq_dat,
    output logic [pREQ_NUM-1:0] oreq_rdy,
    input  logic                ienc_rdy,
    output logic                oenc_sop,
    output logic                oenc_val,
    output logic                oenc_eop,
    output logic                oenc_dat,
    output logic [pIDX_W-1:0]   oenc_tag,
    output logic [pIDX_W-1:0]   ogrant,
    output logic                obusy
);

    state_t              state, state_nxt;
    logic [pIDX_W-1:0]   rr_ptr;
    logic [pIDX_W-1:0]   ptr_inc;
    logic                first_beat;
    logic                term_skip;
    logic [pREQ_NUM-1:0] cand;
    logic                pick_found;
    logic [pIDX_W-1:0]   pick_idx;
    logic                beat_acc;

    assign cand    = ireq_val & ireq_sop;
    assign ptr_inc = pIDX_W'((int'(ogrant) + 1) % pREQ_NUM);
    assign obusy   = (state != IDLE);

    vit_rr_pick #(
        .pREQ_NUM (pREQ_NUM),
        .pIDX_W   (pIDX_W)
    ) u_pick (
        .ireq   (cand),
        .iptr   (rr_ptr),
        .ofound (pick_found),
        .oidx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        oreq_rdy  = '0;
        oenc_val  = 1'b0;
        oenc_sop  = 1'b0;
        oenc_eop  = 1'b0;
        oenc_dat  = ireq_dat[ogrant];
        oenc_tag  = ogrant;
        beat_acc  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found)
                    state_nxt = BUSY;
            end
            BUSY: begin
                oreq_rdy[ogrant] = ienc_rdy;
                oenc_val         = ireq_val[ogrant] & ienc_rdy;
                oenc_sop         = ireq_sop[ogrant] & first_beat;
                oenc_eop         = ireq_eop[ogrant];
                beat_acc         = oenc_val;
                if (beat_acc && ireq_eop[ogrant])
                    state_nxt = TERM;
            end
            TERM: begin
                // The encoder's ready is still stale on the entry cycle.
                if (!term_skip && ienc_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            ogrant     <= '0;
            first_beat <= 1'b0;
            term_skip  <= 1'b0;
        end else if (iclkena) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        ogrant     <= pick_idx;
                        first_beat <= 1'b1;
                    end
                end
                BUSY: begin
                    if (beat_acc)
                        first_beat <= 1'b0;
                    if (state_nxt == TERM) begin
                        rr_ptr    <= ptr_inc;
                        term_skip <= 1'b1;
                    end
                end
                TERM:    term_skip <= 1'b0;
                default: term_skip <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vit_enc_arb.sv
// Scoreboarded bench for vit_enc_arb with behavioural requesters and a K=3 encoder-ready model.
module tb_vit_enc_arb;

    localparam int N = 4;
    localparam int W = 2;
    localparam int K = 3;

    typedef struct packed {
        logic [1:0] id;
        logic       sop;
        logic       eop;
        logic       dat;
    } beat_t;

    logic         iclk, ireset, iclkena;
    logic [N-1:0] ireq_sop, ireq_val, ireq_eop, ireq_dat, oreq_rdy;
    logic         ienc_rdy, oenc_sop, oenc_val, oenc_eop, oenc_dat, obusy;
    logic [W-1:0] oenc_tag, ogrant;

    vit_enc_arb #(.pREQ_NUM(N), .pIDX_W(W)) dut (
        .iclk     (iclk),
        .ireset   (ireset),
        .iclkena  (iclkena),
        .ireq_sop (ireq_sop),
        .ireq_val (ireq_val),
        .ireq_eop (ireq_eop),
        .ireq_dat (ireq_dat),
        .oreq_rdy (oreq_rdy),
        .ienc_rdy (ienc_rdy),
        .oenc_sop (oenc_sop),
        .oenc_val (oenc_val),
        .oenc_eop (oenc_eop),
        .oenc_dat (oenc_dat),
        .oenc_tag (oenc_tag),
        .ogrant   (ogrant),
        .obusy    (obusy)
    );

    beat_t  req_q[$];
    beat_t  exp_q[$];
    int     grants[$];
    int     n_vec = 0, n_err = 0;
    logic   acc [N];
    logic   ev_en = 0, ev_eop = 0, forced = 0;
    int     force_n = 0, n_forced = 0, n_beats = 0, ecyc = 0;
    logic   in_frame = 0, in_term = 0, chk_gap = 0, have_eop = 0;
    int     term_cnt = 0, last_eop = 0, cur_tag = 0;

    initial begin
        iclk = 0;
        forever #5 iclk = ~iclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find_req(input int id);
        for (int k = 0; k < req_q.size(); k++)
            if (int'(req_q[k].id) == id) return k;
        return -1;
    endfunction

    // Requester beats plus the encoder-visible expectation (sop only on beat 0).
    task automatic load_frame(input int id, input int len, input int mid_sop);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.id  = 2'(id);
            b.dat = 1'($urandom_range(0, 1));
            b.eop = (i == len - 1);
            b.sop = (i == 0) || (i == mid_sop);
            req_q.push_back(b);
            b.sop = (i == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while ((req_q.size() != 0 || exp_q.size() != 0 || obusy || in_term) && n < max) begin
            @(posedge iclk); #2;
            n++;
        end
        chk("timeout", n < max, 1);
    endtask

    // Requesters and encoder-ready model, driven just after each rising edge.
    initial begin
        int idx;
        int enc_cnt;
        logic enc_rdy_m;
        ireq_sop = '0; ireq_val = '0; ireq_eop = '0; ireq_dat = '0;
        ienc_rdy = 1'b1; enc_cnt = 0; enc_rdy_m = 1'b1;
        for (int i = 0; i < N; i++) acc[i] = 1'b0;
        forever begin
            @(posedge iclk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    idx = find_req(i);
                    if (idx >= 0) req_q.delete(idx);
                end
            end
            if (ev_en) begin
                if (ev_eop) begin
                    enc_cnt   = K - 1;
                    enc_rdy_m = 1'b1;
                end else if (enc_cnt > 0) begin
                    enc_cnt--;
                    enc_rdy_m = (enc_cnt == 0);
                end
            end
            if (force_n > 0) begin
                ienc_rdy = 1'b0;
                forced   = 1'b1;
                force_n--;
            end else begin
                ienc_rdy = enc_rdy_m;
                forced   = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                idx = find_req(i);
                if (idx >= 0) begin
                    ireq_val[i] = 1'b1;
                    ireq_sop[i] = req_q[idx].sop;
                    ireq_eop[i] = req_q[idx].eop;
                    ireq_dat[i] = req_q[idx].dat;
                end else begin
                    ireq_val[i] = 1'b0;
                    ireq_sop[i] = 1'b0;
                    ireq_eop[i] = 1'b0;
                    ireq_dat[i] = 1'b0;
                end
            end
        end
    end

    // Encoder-side monitor and scoreboard, sampled on the falling edge.
    initial begin
        int    idx;
        beat_t e;
        forever begin
            @(negedge iclk);
            ev_en  = iclkena && !ireset;
            ev_eop = ev_en && oenc_val && oenc_eop;
            for (int i = 0; i < N; i++) acc[i] = ev_en && oreq_rdy[i] && ireq_val[i];
            if (ireset) begin
                in_frame = 1'b0;
                in_term  = 1'b0;
            end else if (iclkena) begin
                ecyc++;
                chk("rdy_onehot", $countones(oreq_rdy) <= 1, 1);
                chk("val_vs_rdy", oenc_val, |(oreq_rdy & ireq_val));
                if (forced) begin
                    chk("forced_rdy", oreq_rdy, 0);
                    chk("forced_val", oenc_val, 0);
                    n_forced++;
                end
                if (oenc_val) begin
                    idx = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (idx < 0 && exp_q[k].id == oenc_tag) idx = k;
                    chk("sb_found", idx >= 0, 1);
                    if (idx >= 0) begin
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        chk("enc_dat", oenc_dat, e.dat);
                        chk("enc_sop", oenc_sop, e.sop);
                        chk("enc_eop", oenc_eop, e.eop);
                    end
                    if (in_frame) chk("interleave", oenc_tag, cur_tag);
                    if (oenc_sop) begin
                        grants.push_back(int'(oenc_tag));
                        if (chk_gap && have_eop) chk("eop_sop_gap", ecyc - last_eop, K + 2);
                    end
                    in_frame = !oenc_eop;
                    cur_tag  = int'(oenc_tag);
                    n_beats++;
                    if (oenc_eop) begin
                        last_eop = ecyc;
                        have_eop = 1'b1;
                        in_term  = 1'b1;
                        term_cnt = 0;
                    end
                end else if (in_term) begin
                    if (obusy) term_cnt++;
                    else begin
                        chk("term_len", term_cnt, K);
                        in_term = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int order2[5] = '{0, 1, 2, 3, 0};
        int base, n, idx;
        ireset = 1'b1; iclkena = 1'b1;

        // All requesters hold sop from reset, req0 has a second frame queued.
        load_frame(0, 4, -1); load_frame(1, 3, -1); load_frame(2, 5, -1);
        load_frame(3, 2, -1); load_frame(0, 3, -1);
        chk_gap = 1'b1; have_eop = 1'b0;
        repeat (3) @(posedge iclk);
        #2;
        chk("rst_busy", obusy, 0);
        chk("rst_rdy", oreq_rdy, 0);
        chk("rst_enc", {oenc_sop, oenc_val, oenc_eop}, 0);
        chk("rst_grant", ogrant, 0);
        ireset = 1'b0;
        wait_done(500);
        chk("t2_ngrants", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++) chk("t2_order", grants[k], order2[k]);
        chk_gap = 1'b0;

        // Single 8-bit frame on req1.
        grants.delete(); base = n_beats;
        load_frame(1, 8, -1);
        @(posedge iclk); #2;
        chk("t1_idle", obusy, 0);
        @(posedge iclk); #2;
        chk("t1_busy", obusy, 1);
        chk("t1_grant", ogrant, 1);
        wait_done(100);
        chk("t1_beats", n_beats - base, 8);

        // Mid-frame sop on req2 beat 3 is masked.
        base = n_beats;
        load_frame(2, 6, 3);
        wait_done(100);
        chk("t3_beats", n_beats - base, 6);

        // Encoder ready held low for 5 cycles mid-frame.
        base = n_beats; n = 0;
        load_frame(1, 10, -1);
        while (n_beats < base + 3 && n < 50) begin @(posedge iclk); #2; n++; end
        chk("t4_start", n < 50, 1);
        n_forced = 0; force_n = 5;
        wait_done(100);
        chk("t4_forced", n_forced, 5);
        chk("t4_beats", n_beats - base, 10);

        // Reset pulsed on beat 4 of a req3 frame.
        base = n_beats; n = 0;
        load_frame(3, 8, -1);
        while (n_beats < base + 4 && n < 50) begin @(posedge iclk); #2; n++; end
        chk("t5_start", n < 50, 1);
        ireset = 1'b1;
        @(posedge iclk); #2;
        ireset = 1'b0;
        chk("t5_idle", obusy, 0);
        chk("t5_rdy", oreq_rdy, 0);
        chk("t5_val", oenc_val, 0);
        for (idx = find_req(3); idx >= 0; idx = find_req(3)) req_q.delete(idx);
        for (int k = exp_q.size() - 1; k >= 0; k--) if (exp_q[k].id == 2'd3) exp_q.delete(k);
        grants.delete();
        load_frame(0, 3, -1); load_frame(3, 3, -1);
        wait_done(100);
        chk("t5_ngrants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("t5_first", grants[0], 0);
            chk("t5_second", grants[1], 3);
        end

        // Single-beat frame with the clock enable toggling every cycle.
        base = n_beats; n = 0;
        load_frame(0, 1, -1);
        while ((req_q.size() != 0 || exp_q.size() != 0 || obusy || in_term) && n < 200) begin
            @(posedge iclk); #2;
            iclkena = ~iclkena;
            n++;
        end
        iclkena = 1'b1;
        chk("t6_timeout", n < 200, 1);
        chk("t6_beats", n_beats - base, 1);
        chk("exp_empty", exp_q.size(), 0);

        repeat (2) @(posedge iclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
